// File: rtl/timing_control_unit.sv
// Timing control unit: sequences the T-cycles of each instruction, the opcode
// fetch, bus direction and the post-reset bus sequence, with ready-driven stalls.
module timing_control_unit #(
  parameter int TCU_WIDTH    = 3,
  parameter int RESET_CYCLES = 7
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic                 i_rdy,
  input  logic [7:0]           i_data,
  output logic [7:0]           o_ir,
  output logic [TCU_WIDTH-1:0] o_tcu,
  output logic                 o_sync,
  output logic                 o_rw,
  output logic                 o_reset_seq,
  output logic                 o_illegal
);

  typedef enum logic [1:0] {
    PH_RESET,
    PH_SEQ,
    PH_RUN
  } phase_t;

  typedef enum logic [2:0] {
    CLS_IMPLIED,
    CLS_IMM,
    CLS_ABS_RD,
    CLS_ABS_WR,
    CLS_JMP,
    CLS_RMW,
    CLS_ILLEGAL
  } op_class_t;

  function automatic op_class_t classify(input logic [7:0] op);
    case (op)
      8'hEA, 8'h18, 8'h38, 8'hE8, 8'hCA,
      8'hC8, 8'h88, 8'hAA, 8'h8A:        return CLS_IMPLIED;
      8'hA9, 8'hA2, 8'hA0, 8'h69:        return CLS_IMM;
      8'hAD, 8'hAE, 8'hAC, 8'h6D:        return CLS_ABS_RD;
      8'h8D, 8'h8E, 8'h8C:               return CLS_ABS_WR;
      8'h4C:                             return CLS_JMP;
      8'hEE, 8'hCE, 8'h0E:               return CLS_RMW;
      default:                           return CLS_ILLEGAL;
    endcase
  endfunction

  // Index of the final cycle T(N-1) for each class.
  function automatic logic [2:0] last_cycle(input op_class_t cls);
    case (cls)
      CLS_ABS_RD, CLS_ABS_WR: return 3'd3;
      CLS_JMP:                return 3'd2;
      CLS_RMW:                return 3'd5;
      default:                return 3'd1;
    endcase
  endfunction

  phase_t               phase_q, phase_d;
  logic [TCU_WIDTH-1:0] tcu_q, tcu_d;
  logic [3:0]           seq_q, seq_d;
  logic [7:0]           ir_q, ir_d;
  op_class_t            cls;
  logic                 run;
  logic                 stall;

  assign cls   = classify(ir_q);
  assign run   = (phase_q == PH_RUN);
  assign stall = o_rw & ~i_rdy;

  // State register
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before this edge, independent of statement order.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      phase_q <= PH_RESET;
      tcu_q   <= '0;
      seq_q   <= '0;
      // NOTE: the instruction register is given a reset value (a NOP) because
      // it is architecturally visible; plain datapath storage would not be.
      ir_q    <= 8'hEA;
    end else begin
      phase_q <= phase_d;
      tcu_q   <= tcu_d;
      seq_q   <= seq_d;
      ir_q    <= ir_d;
    end
  end

  // Next-state logic
  always_comb begin
    // NOTE: every signal gets a hold default first so no path infers a latch.
    phase_d = phase_q;
    tcu_d   = tcu_q;
    seq_d   = seq_q;
    ir_d    = ir_q;
    if (!stall) begin
      case (phase_q)
        PH_RESET: begin
          phase_d = (RESET_CYCLES == 0) ? PH_RUN : PH_SEQ;
          tcu_d   = '0;
          seq_d   = '0;
        end
        PH_SEQ: begin
          if (seq_q == 4'(RESET_CYCLES - 1)) begin
            phase_d = PH_RUN;
            tcu_d   = '0;
          end else begin
            seq_d = seq_q + 4'd1;
            tcu_d = tcu_q + TCU_WIDTH'(1);
          end
        end
        default: begin
          if (tcu_q == '0) begin
            ir_d  = i_data;
            tcu_d = TCU_WIDTH'(1);
          end else if (tcu_q == TCU_WIDTH'(last_cycle(cls))) begin
            tcu_d = '0;
          end else begin
            tcu_d = tcu_q + TCU_WIDTH'(1);
          end
        end
      endcase
    end
  end

  // Outputs decode registered state only; the bus is written only in the
  // store cycle of absolute writes and the two final cycles of RMW.
  always_comb begin
    o_ir        = ir_q;
    o_tcu       = tcu_q;
    o_reset_seq = !run;
    o_sync      = run && (tcu_q == '0);
    o_illegal   = run && (tcu_q == TCU_WIDTH'(1)) && (cls == CLS_ILLEGAL);
    o_rw        = !(run && (((cls == CLS_ABS_WR) && (tcu_q == TCU_WIDTH'(3))) ||
                            ((cls == CLS_RMW) && ((tcu_q == TCU_WIDTH'(4)) ||
                                                  (tcu_q == TCU_WIDTH'(5))))));
  end

endmodule

// File: tb/tb_timing_control_unit.sv
// Directed bench for timing_control_unit: each step drives one cycle of inputs,
// queues the outputs expected after that edge, then pops and compares them.
module tb_timing_control_unit;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       rdy;
  logic [7:0] data;
  logic [7:0] ir;
  logic [2:0] tcu;
  logic       sync_o, rw, reset_seq, illegal;

  always #5 clk = ~clk;

  timing_control_unit #(.TCU_WIDTH(3), .RESET_CYCLES(7)) dut (
    .i_clk      (clk),
    .i_reset_n  (reset_n),
    .i_rdy      (rdy),
    .i_data     (data),
    .o_ir       (ir),
    .o_tcu      (tcu),
    .o_sync     (sync_o),
    .o_rw       (rw),
    .o_reset_seq(reset_seq),
    .o_illegal  (illegal)
  );

  typedef struct packed {
    logic [7:0] ir;
    logic [2:0] tcu;
    logic       sync;
    logic       rw;
    logic       rs;
    logic       ill;
  } obs_t;

  obs_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic step(input string tag, input logic rst_v, input logic rdy_v,
                      input logic [7:0] d, input logic [7:0] e_ir,
                      input logic [2:0] e_tcu, input logic e_sync,
                      input logic e_rw, input logic e_rs, input logic e_ill);
    obs_t e;
    obs_t got;
    @(negedge clk);
    reset_n = rst_v;
    rdy     = rdy_v;
    data    = d;
    exp_q.push_back('{ir: e_ir, tcu: e_tcu, sync: e_sync, rw: e_rw, rs: e_rs, ill: e_ill});
    @(posedge clk);
    #1;
    got = '{ir: ir, tcu: tcu, sync: sync_o, rw: rw, rs: reset_seq, ill: illegal};
    e   = exp_q.pop_front();
    checks++;
    assert (got === e) else begin
      errors++;
      $error("FAIL %s: observed ir=%h tcu=%0d sync=%b rw=%b rs=%b ill=%b, expected ir=%h tcu=%0d sync=%b rw=%b rs=%b ill=%b",
             tag, got.ir, got.tcu, got.sync, got.rw, got.rs, got.ill,
             e.ir, e.tcu, e.sync, e.rw, e.rs, e.ill);
    end
  endtask

  task automatic rst_step(input string tag);
    step(tag, 1'b0, 1'b1, 8'h00, 8'hEA, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic seq_step(input string tag, input logic rdy_v, input logic [2:0] e_tcu);
    step(tag, 1'b1, rdy_v, 8'h00, 8'hEA, e_tcu, 1'b0, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic run_step(input string tag, input logic rdy_v, input logic [7:0] d,
                          input logic [7:0] e_ir, input logic [2:0] e_tcu,
                          input logic e_sync, input logic e_rw, input logic e_ill);
    step(tag, 1'b1, rdy_v, d, e_ir, e_tcu, e_sync, e_rw, 1'b0, e_ill);
  endtask

  initial begin
    reset_n = 1'b0;
    rdy     = 1'b1;
    data    = 8'h00;

    // Reset held, then release into the 7-cycle bus sequence.
    rst_step("rst_hold0");
    rst_step("rst_hold1");
    for (int i = 0; i < 7; i++) seq_step($sformatf("seq%0d", i), 1'b1, 3'(i));
    run_step("first_t0",   1'b1, 8'h00, 8'hEA, 3'd0, 1'b1, 1'b1, 1'b0);

    // NOP
    run_step("nop_t1",     1'b1, 8'hEA, 8'hEA, 3'd1, 1'b0, 1'b1, 1'b0);
    run_step("nop_t0",     1'b1, 8'h33, 8'hEA, 3'd0, 1'b1, 1'b1, 1'b0);

    // STA abs; ready low in the write cycle must not stall.
    run_step("sta_t1",     1'b1, 8'h8D, 8'h8D, 3'd1, 1'b0, 1'b1, 1'b0);
    run_step("sta_t2",     1'b1, 8'h11, 8'h8D, 3'd2, 1'b0, 1'b1, 1'b0);
    run_step("sta_t3",     1'b1, 8'h22, 8'h8D, 3'd3, 1'b0, 1'b0, 1'b0);
    run_step("sta_t0",     1'b0, 8'h44, 8'h8D, 3'd0, 1'b1, 1'b1, 1'b0);

    // INC abs
    run_step("inc_t1",     1'b1, 8'hEE, 8'hEE, 3'd1, 1'b0, 1'b1, 1'b0);
    run_step("inc_t2",     1'b1, 8'h01, 8'hEE, 3'd2, 1'b0, 1'b1, 1'b0);
    run_step("inc_t3",     1'b1, 8'h02, 8'hEE, 3'd3, 1'b0, 1'b1, 1'b0);
    run_step("inc_t4",     1'b1, 8'h03, 8'hEE, 3'd4, 1'b0, 1'b0, 1'b0);
    run_step("inc_t5",     1'b1, 8'h04, 8'hEE, 3'd5, 1'b0, 1'b0, 1'b0);
    run_step("inc_t0",     1'b1, 8'h05, 8'hEE, 3'd0, 1'b1, 1'b1, 1'b0);

    // LDA abs with a three-cycle stall at T2.
    run_step("lda_t1",     1'b1, 8'hAD, 8'hAD, 3'd1, 1'b0, 1'b1, 1'b0);
    run_step("lda_t2",     1'b1, 8'h66, 8'hAD, 3'd2, 1'b0, 1'b1, 1'b0);
    run_step("lda_stall0", 1'b0, 8'h77, 8'hAD, 3'd2, 1'b0, 1'b1, 1'b0);
    run_step("lda_stall1", 1'b0, 8'h88, 8'hAD, 3'd2, 1'b0, 1'b1, 1'b0);
    run_step("lda_stall2", 1'b0, 8'h99, 8'hAD, 3'd2, 1'b0, 1'b1, 1'b0);
    run_step("lda_t3",     1'b1, 8'hAA, 8'hAD, 3'd3, 1'b0, 1'b1, 1'b0);
    run_step("lda_t0",     1'b1, 8'hBB, 8'hAD, 3'd0, 1'b1, 1'b1, 1'b0);

    // Stall during fetch must not load the opcode; then JMP abs.
    run_step("fetch_stall",1'b0, 8'h4C, 8'hAD, 3'd0, 1'b1, 1'b1, 1'b0);
    run_step("jmp_t1",     1'b1, 8'h4C, 8'h4C, 3'd1, 1'b0, 1'b1, 1'b0);
    run_step("jmp_t2",     1'b1, 8'h12, 8'h4C, 3'd2, 1'b0, 1'b1, 1'b0);
    run_step("jmp_t0",     1'b1, 8'h34, 8'h4C, 3'd0, 1'b1, 1'b1, 1'b0);

    // Illegal opcode, then an immediate.
    run_step("ill_t1",     1'b1, 8'h02, 8'h02, 3'd1, 1'b0, 1'b1, 1'b1);
    run_step("ill_t0",     1'b1, 8'h56, 8'h02, 3'd0, 1'b1, 1'b1, 1'b0);
    run_step("imm_t1",     1'b1, 8'hA9, 8'hA9, 3'd1, 1'b0, 1'b1, 1'b0);
    run_step("imm_t0",     1'b1, 8'h78, 8'hA9, 3'd0, 1'b1, 1'b1, 1'b0);

    // Reset during the first write cycle of INC abs.
    run_step("inc2_t1",    1'b1, 8'hEE, 8'hEE, 3'd1, 1'b0, 1'b1, 1'b0);
    run_step("inc2_t2",    1'b1, 8'h00, 8'hEE, 3'd2, 1'b0, 1'b1, 1'b0);
    run_step("inc2_t3",    1'b1, 8'h00, 8'hEE, 3'd3, 1'b0, 1'b1, 1'b0);
    run_step("inc2_t4",    1'b1, 8'h00, 8'hEE, 3'd4, 1'b0, 1'b0, 1'b0);
    rst_step("mid_rst0");
    rst_step("mid_rst1");

    // Full sequence again, with a stall inside it.
    seq_step("rseq0",  1'b1, 3'd0);
    seq_step("rseq1",  1'b1, 3'd1);
    seq_step("rseq2",  1'b1, 3'd2);
    seq_step("rstall0",1'b0, 3'd2);
    seq_step("rstall1",1'b0, 3'd2);
    seq_step("rseq3",  1'b1, 3'd3);
    seq_step("rseq4",  1'b1, 3'd4);
    seq_step("rseq5",  1'b1, 3'd5);
    seq_step("rseq6",  1'b1, 3'd6);
    run_step("rt0",    1'b1, 8'h00, 8'hEA, 3'd0, 1'b1, 1'b1, 1'b0);
    run_step("rt1",    1'b1, 8'h18, 8'h18, 3'd1, 1'b0, 1'b1, 1'b0);
    run_step("rt0b",   1'b1, 8'h00, 8'h18, 3'd0, 1'b1, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/timing_control_unit.md
TIMING_CONTROL_UNIT -- requirements
Module: timing_control_unit

Interface
REQ-001 SHALL have parameter TCU_WIDTH, default 3: width of the cycle counter o_tcu; legal values 3..8.
REQ-002 SHALL have parameter RESET_CYCLES, default 7: length of the post-reset bus sequence; legal values 0..15.
REQ-003 SHALL have port i_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port i_reset_n, input, 1 bit: reset, synchronous, active-low.
REQ-005 SHALL have port i_rdy, input, 1 bit: ready; low requests a stall.
REQ-006 SHALL have port i_data, input, 8 bits: data bus; carries the opcode during the fetch cycle.
REQ-007 SHALL have port o_ir, output, 8 bits: instruction register.
REQ-008 SHALL have port o_tcu, output, TCU_WIDTH bits: cycle index within the current instruction.
REQ-009 SHALL have port o_sync, output, 1 bit: high during an opcode-fetch cycle.
REQ-010 SHALL have port o_rw, output, 1 bit: 1 = read, 0 = write.
REQ-011 SHALL have port o_reset_seq, output, 1 bit: high while the post-reset sequence runs.
REQ-012 SHALL have port o_illegal, output, 1 bit: high in cycle T1 of an unsupported opcode.

Function
REQ-013 SHALL drive all outputs only from registered state; no combinational path from i_data or i_rdy to any output.
REQ-014 SHALL number instruction cycles T0..T(N-1); T0 is the fetch cycle (o_sync=1, o_tcu=0).
REQ-015 SHALL load i_data into o_ir at the end of T0 when i_rdy=1; o_ir SHALL hold at all other times.
REQ-016 SHALL set N from o_ir by opcode class:
- Implied (EA, 18, 38, E8, CA, C8, 88, AA, 8A): N=2.
- Immediate (A9, A2, A0, 69): N=2.
- Absolute read (AD, AE, AC, 6D): N=4.
- Absolute write (8D, 8E, 8C): N=4.
- JMP absolute (4C): N=3.
- Absolute read-modify-write (EE, CE, 0E): N=6.
- Every other opcode: N=2.
REQ-017 SHALL drive o_rw=0 only in these cycles: T3 of the absolute-write class, and T4 and T5 of the read-modify-write class; o_rw=1 in every other cycle, including the reset sequence.
REQ-018 SHALL, after cycle T(N-1) completes, make the next cycle T0 with o_sync=1; no idle cycles between instructions.
REQ-019 SHALL drive o_illegal=1 only in cycle T1 of an opcode outside the REQ-016 lists; such an opcode SHALL execute as N=2 with reads only.
REQ-020 SHALL, when i_rdy=0 in a read cycle (o_rw=1), hold o_tcu, o_ir, the reset-sequence counter and all outputs unchanged for that cycle.
REQ-021 SHALL ignore i_rdy in write cycles (o_rw=0) and advance normally.
REQ-022 SHALL run a post-reset sequence when i_reset_n returns high: RESET_CYCLES cycles with o_reset_seq=1, o_sync=0, o_rw=1, o_tcu counting 0..RESET_CYCLES-1 modulo 2^TCU_WIDTH.
REQ-023 SHALL make the cycle after the last post-reset cycle T0; with RESET_CYCLES=0, the first cycle after reset release SHALL be T0.
REQ-024 SHALL stall the post-reset sequence on i_rdy=0, since every cycle in it is a read.

Reset
REQ-025 SHALL, in any cycle where i_reset_n=0 is sampled, abort the current instruction or sequence, including mid-write, with no further write cycles.
REQ-026 SHALL hold these output values while i_reset_n=0: o_ir=8'hEA, o_tcu=0, o_sync=0, o_rw=1, o_reset_seq=1, o_illegal=0.
REQ-027 SHALL hold the reset state for as long as i_reset_n=0 and restart the full post-reset sequence on release.

Verification
REQ-028 SHALL cover reset release with defaults: 7 cycles with o_reset_seq=1 and o_tcu 0..6, then T0; i_data=EA gives o_ir=EA, o_sync pattern 1,0,1, o_tcu 0,1,0.
REQ-029 SHALL cover STA abs (8D): o_tcu 0,1,2,3 with o_rw 1,1,1,0, then o_sync=1.
REQ-030 SHALL cover INC abs (EE): o_tcu 0..5 with o_rw=0 only at T4 and T5.
REQ-031 SHALL cover stalls: i_rdy=0 for 3 cycles at T2 of LDA abs (AD) holds o_tcu=2 for 4 cycles total; i_rdy=0 at T3 of 8D does not stall.
REQ-032 SHALL cover an illegal opcode: i_data=02 at T0 gives o_illegal=1 at T1, then T0 follows.
REQ-033 SHALL cover reset mid-instruction: i_reset_n=0 at T4 of EE gives o_rw=1, o_sync=0 and o_tcu=0 in the next cycle, and the full reset sequence after release.
